hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Drives the PC write enable, the IF/ID write and flush, the ID/EX flush and hold, and the EX/MEM hold.
- Resolves load-use hazards, EX-stage redirects (taken branch or jump) and multi-cycle data-memory waits.
- Also provides a post-reset boot hold and saturating stall and flush statistics counters.

Parameters:
- BOOT_CYCLES, 2, number of cycles after reset release during which the pipeline is held flushed (minimum 1).
- CNT_W, 16, width of the statistics counters.
- MEM_TIMEOUT, 64, number of MEM_WAIT cycles after which the mem_timeout flag sets.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- ID_ReadRegNum1  input  5  rs1 of the instruction in ID
- ID_ReadRegNum2  input  5  rs2 of the instruction in ID
- ID_uses_rs1  input  1  ID instruction reads rs1
- ID_uses_rs2  input  1  ID instruction reads rs2
- EX_cntl_MemRead  input  1  instruction in EX is a load
- EX_WriteRegNum  input  5  rd of the instruction in EX
- EX_redirect  input  1  EX resolved a taken branch or jump
- MEM_dmem_req  input  1  instruction in MEM is accessing data memory
- dmem_ready  input  1  data memory completes its access this cycle
- PC_write  output  1  PC register load enable
- IF_IDWrite  output  1  IF/ID register load enable
- IF_IDFlush  output  1  IF/ID register clears to NOP
- ID_EXFlush  output  1  ID/EX register clears to bubble
- ID_EXHold  output  1  ID/EX register keeps its value
- EX_MEMHold  output  1  EX/MEM register keeps its value
- mem_timeout  output  1  sticky flag: memory wait exceeded MEM_TIMEOUT
- stall_cnt  output  CNT_W  saturating count of cycles with PC_write=0 outside BOOT
- flush_cnt  output  CNT_W  saturating count of redirect flushes

Behaviour:
- Reset is asynchronous, active-low, on reset_n; the block is clocked on clk.
- While in reset:
  - state=BOOT, boot counter=0.
  - stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0.
  - Outputs: PC_write=0, IF_IDWrite=0, IF_IDFlush=1, ID_EXFlush=1, ID_EXHold=0, EX_MEMHold=0.
- Reset asserted mid-operation forces BOOT immediately from any state; all counters and flags clear.
- States: BOOT, RUN, MEM_WAIT. Outputs are a combinational function of the registered state and the current inputs (Mealy).
- BOOT:
  - Outputs are the same as the reset values; the boot counter increments each cycle.
  - After BOOT_CYCLES cycles in BOOT, go to RUN.
  - Inputs are ignored and counters do not count.
- RUN, evaluated in priority order each cycle:
  - 1) Memory stall: MEM_dmem_req=1 and dmem_ready=0.
    - Freeze all: PC_write=0, IF_IDWrite=0, ID_EXHold=1, EX_MEMHold=1, no flushes.
    - Next state MEM_WAIT; wait counter loads 1.
  - 2) Redirect: EX_redirect=1.
    - PC_write=1, IF_IDWrite=1, IF_IDFlush=1, ID_EXFlush=1.
    - flush_cnt increments. Redirect beats load-use.
  - 3) Load-use: EX_cntl_MemRead=1, EX_WriteRegNum!=0, and either (ID_uses_rs1 and ID_ReadRegNum1==EX_WriteRegNum) or (ID_uses_rs2 and ID_ReadRegNum2==EX_WriteRegNum).
    - PC_write=0, IF_IDWrite=0, ID_EXFlush=1 (one bubble).
  - 4) Otherwise: PC_write=1, IF_IDWrite=1, all flushes and holds 0.
- MEM_WAIT:
  - If dmem_ready=0: freeze all, as in RUN case 1. Wait counter increments, saturating at MEM_TIMEOUT.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - If dmem_ready=1: outputs follow RUN rules 2-4 (rule 1 is not re-evaluated this cycle); next state RUN; wait counter clears.
- Simultaneous events:
  - Redirect or load-use arriving during a freeze is not acted on. The EX contents are held, so the condition re-presents on the release cycle.
  - A new MEM_dmem_req with dmem_ready=0 on the cycle after release re-enters MEM_WAIT.
- Statistics:
  - stall_cnt increments on every RUN or MEM_WAIT cycle with PC_write=0.
  - Both stall_cnt and flush_cnt saturate at 2^CNT_W-1 and do not wrap.
- x0 never causes a load-use stall.

Test Plan:
- Reset, then release with BOOT_CYCLES=2 -> IF_IDFlush=ID_EXFlush=1 and PC_write=0 for exactly 2 cycles, then PC_write=1; reassert reset_n=0 mid-RUN -> BOOT outputs immediately and stall_cnt=0.
- Load-use: EX_cntl_MemRead=1, EX_WriteRegNum=5, ID_ReadRegNum2=5, ID_uses_rs2=1 -> PC_write=0, IF_IDWrite=0, ID_EXFlush=1 for one cycle, stall_cnt=1. Same stimulus with rd=0, or with ID_uses_rs2=0 -> no stall.
- Load-use and EX_redirect=1 in the same cycle -> IF_IDFlush=ID_EXFlush=1, PC_write=1, flush_cnt +1, stall_cnt unchanged.
- MEM_dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles (ID_EXHold=EX_MEMHold=1); release cycle PC_write=1; stall_cnt=3.
- Hold dmem_ready=0 for 70 cycles with MEM_TIMEOUT=64 -> mem_timeout rises when the wait counter reaches 64 and stays 1 after release; EX_redirect pulsed during the freeze is acted on only at release.
- Force 2^CNT_W+5 redirects (CNT_W=4 build) -> flush_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// EX redirects, data-memory wait freezes, post-reset boot hold and statistics.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       ID_ReadRegNum1,
    input  logic [4:0]       ID_ReadRegNum2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_cntl_MemRead,
    input  logic [4:0]       EX_WriteRegNum,
    input  logic             EX_redirect,
    input  logic             MEM_dmem_req,
    input  logic             dmem_ready,
    output logic             PC_write,
    output logic             IF_IDWrite,
    output logic             IF_IDFlush,
    output logic             ID_EXFlush,
    output logic             ID_EXHold,
    output logic             EX_MEMHold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [BOOT_W-1:0]   boot_cnt, boot_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                load_use;
    logic                freeze;
    logic                use_rules;
    logic                redirect_taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) &&
                      ((ID_uses_rs1 && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                       (ID_uses_rs2 && (ID_ReadRegNum2 == EX_WriteRegNum)));

    always_comb begin
        state_nxt      = state;
        boot_nxt       = boot_cnt;
        wait_nxt       = wait_cnt;
        freeze         = 1'b0;
        use_rules      = 1'b0;
        redirect_taken = 1'b0;
        PC_write       = 1'b0;
        IF_IDWrite     = 1'b0;
        IF_IDFlush     = 1'b0;
        ID_EXFlush     = 1'b0;
        ID_EXHold      = 1'b0;
        EX_MEMHold     = 1'b0;

        case (state)
            BOOT: begin
                IF_IDFlush = 1'b1;
                ID_EXFlush = 1'b1;
                boot_nxt   = boot_cnt + BOOT_W'(1);
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = RUN;
                    boot_nxt  = '0;
                end
            end
            RUN: begin
                if (MEM_dmem_req && !dmem_ready) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    use_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    freeze   = 1'b1;
                    wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
                end else begin
                    // release cycle: the held memory request is not re-checked
                    use_rules = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = BOOT;
                boot_nxt  = '0;
            end
        endcase

        if (freeze) begin
            ID_EXHold  = 1'b1;
            EX_MEMHold = 1'b1;
        end

        if (use_rules) begin
            if (EX_redirect) begin
                redirect_taken = 1'b1;
                PC_write       = 1'b1;
                IF_IDWrite     = 1'b1;
                IF_IDFlush     = 1'b1;
                ID_EXFlush     = 1'b1;
            end else if (load_use) begin
                ID_EXFlush = 1'b1;
            end else begin
                PC_write   = 1'b1;
                IF_IDWrite = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            boot_cnt    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_nxt;
            wait_cnt <= wait_nxt;
            if (freeze && (wait_nxt == WAIT_MAX))
                mem_timeout <= 1'b1;
            if ((state != BOOT) && !PC_write)
                stall_cnt <= sat_inc(stall_cnt);
            if (redirect_taken)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl with a queue-based scoreboard
// fed by a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [4:0]       ID_ReadRegNum1 = '0, ID_ReadRegNum2 = '0, EX_WriteRegNum = '0;
    logic             ID_uses_rs1 = 0, ID_uses_rs2 = 0, EX_cntl_MemRead = 0;
    logic             EX_redirect = 0, MEM_dmem_req = 0, dmem_ready = 1;
    logic             PC_write, IF_IDWrite, IF_IDFlush, ID_EXFlush, ID_EXHold, EX_MEMHold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
        .EX_redirect(EX_redirect), .MEM_dmem_req(MEM_dmem_req), .dmem_ready(dmem_ready),
        .PC_write(PC_write), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
        .ID_EXFlush(ID_EXFlush), .ID_EXHold(ID_EXHold), .EX_MEMHold(EX_MEMHold),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {PC_write, IF_IDWrite, IF_IDFlush, ID_EXFlush, ID_EXHold, EX_MEMHold}
    typedef struct {
        logic [5:0] ctl;
        logic       tmo;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // reference model state
    int boot_left = BOOT_CYCLES;
    bit waiting   = 0;
    int wait_len  = 0;
    bit tmo_m     = 0;
    int sc_m      = 0;
    int fc_m      = 0;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_push();
        exp_t e;
        bit   lu;
        if (!reset_n) begin
            boot_left = BOOT_CYCLES; waiting = 0; wait_len = 0;
            tmo_m = 0; sc_m = 0; fc_m = 0;
            e.ctl = 6'b001100; e.tmo = 0; e.sc = 0; e.fc = 0;
            q.push_back(e);
            return;
        end
        e.tmo = tmo_m; e.sc = sc_m; e.fc = fc_m;
        lu = EX_cntl_MemRead && EX_WriteRegNum != 0 &&
             ((ID_uses_rs1 && ID_ReadRegNum1 == EX_WriteRegNum) ||
              (ID_uses_rs2 && ID_ReadRegNum2 == EX_WriteRegNum));
        if (boot_left > 0) begin
            e.ctl = 6'b001100;
            boot_left--;
        end else begin
            if (waiting ? !dmem_ready : (MEM_dmem_req && !dmem_ready)) begin
                e.ctl    = 6'b000011;
                wait_len = waiting ? ((wait_len >= MEM_TIMEOUT) ? MEM_TIMEOUT : wait_len + 1) : 1;
                waiting  = 1;
                if (wait_len == MEM_TIMEOUT) tmo_m = 1;
            end else begin
                waiting = 0; wait_len = 0;
                if (EX_redirect) begin
                    e.ctl = 6'b111100;
                    fc_m  = sat(fc_m);
                end else if (lu) e.ctl = 6'b000100;
                else             e.ctl = 6'b110000;
            end
            if (!e.ctl[5]) sc_m = sat(sc_m);
        end
        q.push_back(e);
    endtask

    task automatic cyc(input bit rn, input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input bit mr, input logic [4:0] wr,
                       input bit redir, input bit req, input bit rdy);
        @(posedge clk);
        #1;
        reset_n = rn; ID_ReadRegNum1 = r1; ID_ReadRegNum2 = r2;
        ID_uses_rs1 = u1; ID_uses_rs2 = u2; EX_cntl_MemRead = mr; EX_WriteRegNum = wr;
        EX_redirect = redir; MEM_dmem_req = req; dmem_ready = rdy;
        model_push();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // monitor: one expected response per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if ({PC_write, IF_IDWrite, IF_IDFlush, ID_EXFlush, ID_EXHold, EX_MEMHold} != e.ctl) begin
                failures++;
                $display("FAIL ctl t=%0t actual=%b required=%b", $time,
                         {PC_write, IF_IDWrite, IF_IDFlush, ID_EXFlush, ID_EXHold, EX_MEMHold}, e.ctl);
            end
            if (mem_timeout !== e.tmo) begin
                failures++;
                $display("FAIL mem_timeout t=%0t actual=%b required=%b", $time, mem_timeout, e.tmo);
            end
            if (stall_cnt !== CNT_W'(e.sc)) begin
                failures++;
                $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, e.sc);
            end
            if (flush_cnt !== CNT_W'(e.fc)) begin
                failures++;
                $display("FAIL flush_cnt t=%0t actual=%0d required=%0d", $time, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        // reset, then boot hold and normal flow
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        // load-use on rs2, then rd=x0 and rs2 unused variants
        cyc(1, 0, 5, 0, 1, 1, 5, 0, 0, 1);
        idle(1);
        cyc(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        cyc(1, 0, 5, 0, 0, 1, 5, 0, 0, 1);
        cyc(1, 7, 0, 1, 0, 1, 7, 0, 0, 1);
        idle(1);
        // load-use together with redirect
        cyc(1, 0, 5, 0, 1, 1, 5, 1, 0, 1);
        idle(1);
        // three-cycle memory wait, then release
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // fresh counters, then a 70-cycle wait crossing the timeout with a redirect pulse
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        for (int i = 0; i < 70; i++) cyc(1, 0, 0, 0, 0, 0, 0, (i == 30), 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        // flush counter saturation
        for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // reset in the middle of running
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            bit rn;
            rn = ($urandom_range(0, 249) != 0);
            cyc(rn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) < 3));
        end
        idle(2);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
